mem_access_unit: RTL and testbench

//  MEM-stage load/store unit of the MIPS pipeline; sits directly upstream of Data_memory and drives its

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sub-word loads with extension, sub-word stores by
// read-modify-write on a word-only data memory, and alignment/range faulting.
module mem_access_unit #(
  parameter int unsigned DMEM_WORDS  = 256,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic [2:0]  ReqOp,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        Ready,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        AddrErr,
  output logic [31:0] DmemAddr,
  output logic        DmemWrite,
  output logic [31:0] DmemWrData,
  input  logic [31:0] DmemRdData
);

  // state  | meaning
  // IDLE   | waiting for a request, Ready high
  // LOAD   | word read in flight, lane extracted at end of cycle
  // STORE  | full-word write strobe for one cycle
  // RMW_RD | read old word, merge store lane(s) into mergeReg
  // RMW_WR | write merged word back to the same address
  // FAULT  | misaligned or out-of-range, no memory access
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_t      state;
  state_t      nextState;
  logic [2:0]  opReg;
  logic [31:0] addrReg;
  logic [31:0] dataReg;
  logic [31:0] mergeReg;

  logic        accept;
  logic        misaligned;
  logic        outOfRange;
  logic        reqFault;
  logic [31:0] wordIdx;
  logic [31:0] wordAddr;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadVal;
  logic [31:0] mergeVal;

  assign Ready    = (state == IDLE) && Rst_n;
  assign accept   = Req && Ready;
  assign wordIdx  = {2'b00, ReqAddr[31:2]};
  assign wordAddr = {addrReg[31:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    case (ReqOp)
      OP_LW, OP_SW:         misaligned = (ReqAddr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = ReqAddr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign outOfRange = RANGE_CHECK && (wordIdx >= DMEM_WORDS);
  assign reqFault   = misaligned || outOfRange;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reqFault)                              nextState = FAULT;
          else if (ReqOp == OP_SW)                   nextState = STORE;
          else if (ReqOp == OP_SH || ReqOp == OP_SB) nextState = RMW_RD;
          else                                       nextState = LOAD;
        end
      end
      RMW_RD:  nextState = RMW_WR;
      default: nextState = IDLE;
    endcase
  end

  // Write strobe is gated by reset so a store caught mid-flight never lands.
  always_comb begin
    DmemAddr   = '0;
    DmemWrite  = 1'b0;
    DmemWrData = '0;
    case (state)
      LOAD, RMW_RD: DmemAddr = wordAddr;
      STORE: begin
        DmemAddr   = wordAddr;
        DmemWrite  = Rst_n;
        DmemWrData = Rst_n ? dataReg : '0;
      end
      RMW_WR: begin
        DmemAddr   = wordAddr;
        DmemWrite  = Rst_n;
        DmemWrData = Rst_n ? mergeReg : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    loadByte = DmemRdData[{addrReg[1:0], 3'b000} +: 8];
    loadHalf = addrReg[1] ? DmemRdData[31:16] : DmemRdData[15:0];
    case (opReg)
      OP_LW:   loadVal = DmemRdData;
      OP_LH:   loadVal = {{16{loadHalf[15]}}, loadHalf};
      OP_LHU:  loadVal = {16'h0000, loadHalf};
      OP_LB:   loadVal = {{24{loadByte[7]}}, loadByte};
      OP_LBU:  loadVal = {24'h000000, loadByte};
      default: loadVal = '0;
    endcase
  end

  always_comb begin
    mergeVal = DmemRdData;
    if (opReg == OP_SH)
      mergeVal[{addrReg[1], 4'b0000} +: 16] = dataReg[15:0];
    else
      mergeVal[{addrReg[1:0], 3'b000} +: 8] = dataReg[7:0];
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      opReg     <= '0;
      addrReg   <= '0;
      dataReg   <= '0;
      mergeReg  <= '0;
      RespValid <= 1'b0;
      RespData  <= '0;
      AddrErr   <= 1'b0;
    end else begin
      state     <= nextState;
      RespValid <= 1'b0;
      AddrErr   <= 1'b0;
      if (accept) begin
        opReg   <= ReqOp;
        addrReg <= ReqAddr;
        dataReg <= ReqData;
      end
      case (state)
        LOAD: begin
          RespValid <= 1'b1;
          RespData  <= loadVal;
        end
        STORE, RMW_WR: begin
          RespValid <= 1'b1;
          RespData  <= '0;
        end
        RMW_RD: mergeReg <= mergeVal;
        FAULT: begin
          RespValid <= 1'b1;
          AddrErr   <= 1'b1;
          RespData  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic checked
// against a word-array reference model of the data memory.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req = 1'b0;
  logic [2:0]  ReqOp = '0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqData = '0;
  logic        Ready, RespValid, AddrErr, DmemWrite;
  logic [31:0] RespData, DmemAddr, DmemWrData, DmemRdData;

  logic [31:0] mem    [0:255];
  logic [31:0] refMem [0:255];
  logic        tbWe = 1'b0;
  logic [7:0]  tbIdx = '0;
  logic [31:0] tbDat = '0;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  mem_access_unit #(.DMEM_WORDS(256), .RANGE_CHECK(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqOp(ReqOp), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .Ready(Ready), .RespValid(RespValid), .RespData(RespData),
    .AddrErr(AddrErr), .DmemAddr(DmemAddr), .DmemWrite(DmemWrite),
    .DmemWrData(DmemWrData), .DmemRdData(DmemRdData)
  );

  assign DmemRdData = mem[DmemAddr[9:2]];

  always @(posedge Clk) begin
    if (tbWe) mem[tbIdx] <= tbDat;
    else if (DmemWrite) mem[DmemAddr[9:2]] <= DmemWrData;
  end

  // Reference: plain arithmetic on a word array, one call per transaction.
  task automatic model_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] expRd, output logic expErr,
                           output int expLat, output int expWrs);
    int idx, sh, v;
    bit mis;
    logic [31:0] w, mask;
    idx = int'(addr >> 2);
    sh  = 8 * int'(addr % 4);
    if (op == 0 || op == 5) mis = (addr % 4) != 0;
    else if (op == 1 || op == 2 || op == 6) mis = (addr % 2) != 0;
    else mis = 1'b0;
    expErr = mis || (idx >= 256);
    expRd = '0; expWrs = 0; expLat = 2;
    if (expErr) return;
    w = refMem[idx];
    case (op)
      3'd0: expRd = w;
      3'd1, 3'd2: begin
        v = int'((w >> sh) & 32'hFFFF);
        if (op == 1 && v >= 32768) v -= 65536;
        expRd = 32'(v);
      end
      3'd3, 3'd4: begin
        v = int'((w >> sh) & 32'hFF);
        if (op == 3 && v >= 128) v -= 256;
        expRd = 32'(v);
      end
      3'd5: begin refMem[idx] = data; expWrs = 1; end
      default: begin
        mask = (op == 6) ? 32'hFFFF : 32'hFF;
        refMem[idx] = (w & ~(mask << sh)) | ((data & mask) << sh);
        expWrs = 1; expLat = 3;
      end
    endcase
  endtask

  // Issue one request, then report what the DUT did until its response.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int wrs, output logic [31:0] wrAddr, output int rdyLow);
    int guard;
    guard = 0; wrs = 0; rdyLow = 0; wrAddr = '0;
    @(negedge Clk);
    Req = 1'b1; ReqOp = op; ReqAddr = addr; ReqData = data;
    while (!Ready && guard < 20) begin @(negedge Clk); guard++; end
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    Req = 1'b0;
    while (!RespValid && guard < 40) begin
      if (DmemWrite) begin wrs++; wrAddr = DmemAddr; end
      if (!Ready) rdyLow++;
      @(posedge Clk); lat++;
      @(negedge Clk); guard++;
    end
    if (!RespValid) lat = -1;
    rd = RespData; err = AddrErr;
  endtask

  task automatic preload();
    Rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk);
      tbWe = 1'b1; tbIdx = 8'(i); tbDat = $urandom;
      refMem[i] = tbDat;
    end
    @(negedge Clk);
    tbWe = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      total++; if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", Ready); end
      total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL reset_respvalid got=%b want=0", RespValid); end
      total++; if (DmemWrite !== 1'b0) begin bad++; $display("FAIL reset_dmemwrite got=%b want=0", DmemWrite); end
      total++; if (DmemAddr !== 32'h0) begin bad++; $display("FAIL reset_dmemaddr got=%h want=0", DmemAddr); end
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", Ready); end
    total++; if (RespData !== 32'h0) begin bad++; $display("FAIL reset_respdata got=%h want=0", RespData); end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd, wa, er; logic err, ee; int lat, wrs, rl, el, ew;
    model_txn(3'd5, 32'h8, 32'hDEADBEEF, er, ee, el, ew);
    do_txn(3'd5, 32'h8, 32'hDEADBEEF, rd, err, lat, wrs, wa, rl);
    total++; if (wrs !== 1) begin bad++; $display("FAIL sw_writes got=%0d want=1", wrs); end
    total++; if (wa !== 32'h8) begin bad++; $display("FAIL sw_addr got=%h want=8", wa); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    do_txn(3'd0, 32'h8, 32'h0, rd, err, lat, wrs, wa, rl);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", rd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL lw_err got=%b want=0", err); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
  endtask

  task automatic test_load_ext();
    logic [2:0] ops [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [31:0] ads [4] = '{32'hB, 32'hB, 32'hA, 32'h8};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] rd, wa; logic err; int lat, wrs, rl;
    for (int i = 0; i < 4; i++) begin
      do_txn(ops[i], ads[i], 32'h0, rd, err, lat, wrs, wa, rl);
      total++; if (rd !== exp[i]) begin bad++; $display("FAIL load_ext[%0d] got=%h want=%h", i, rd, exp[i]); end
      total++; if (err !== 1'b0 || wrs !== 0) begin bad++; $display("FAIL load_ext_side[%0d] err=%b wrs=%0d want 0/0", i, err, wrs); end
    end
  endtask

  task automatic test_sb_rmw();
    logic [31:0] rd, wa, er; logic err, ee; int lat, wrs, rl, el, ew;
    model_txn(3'd7, 32'h9, 32'h55, er, ee, el, ew);
    do_txn(3'd7, 32'h9, 32'h55, rd, err, lat, wrs, wa, rl);
    total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
    total++; if (rl !== 2) begin bad++; $display("FAIL sb_ready_low got=%0d want=2", rl); end
    total++; if (wrs !== 1 || wa !== 32'h8) begin bad++; $display("FAIL sb_write got=%0d@%h want=1@8", wrs, wa); end
    do_txn(3'd0, 32'h8, 32'h0, rd, err, lat, wrs, wa, rl);
    total++; if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_readback got=%h want=dead55ef", rd); end
  endtask

  task automatic test_faults();
    logic [2:0] ops [3] = '{3'd0, 3'd6, 3'd0};
    logic [31:0] ads [3] = '{32'h6, 32'h3, 32'h400};
    logic [31:0] rd, wa; logic err; int lat, wrs, rl;
    for (int i = 0; i < 3; i++) begin
      do_txn(ops[i], ads[i], 32'hFFFFFFFF, rd, err, lat, wrs, wa, rl);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL fault_err[%0d] got=%b want=1", i, err); end
      total++; if (wrs !== 0 || rd !== 32'h0) begin bad++; $display("FAIL fault_side[%0d] wrs=%0d data=%h want 0/0", i, wrs, rd); end
      total++; if (lat !== 2) begin bad++; $display("FAIL fault_latency[%0d] got=%0d want=2", i, lat); end
    end
    @(negedge Clk);
    total++; if (AddrErr !== 1'b0) begin bad++; $display("FAIL fault_pulse got=%b want=0", AddrErr); end
  endtask

  task automatic test_reset_in_rmw();
    @(negedge Clk);
    Req = 1'b1; ReqOp = 3'd6; ReqAddr = 32'h8; ReqData = 32'h00001234;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    total++; if (DmemWrite !== 1'b1) begin bad++; $display("FAIL rmw_wr_strobe got=%b want=1", DmemWrite); end
    Rst_n = 1'b0;
    #1;
    total++; if (DmemWrite !== 1'b0) begin bad++; $display("FAIL rst_gates_write got=%b want=0", DmemWrite); end
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    total++; if (RespValid !== 1'b0 || Ready !== 1'b1) begin bad++; $display("FAIL rst_rmw_state rv=%b rdy=%b want 0/1", RespValid, Ready); end
    @(negedge Clk);
    total++; if (RespValid !== 1'b0) begin bad++; $display("FAIL rst_rmw_resp got=%b want=0", RespValid); end
    total++; if (mem[2] !== refMem[2]) begin bad++; $display("FAIL rst_rmw_mem got=%h want=%h", mem[2], refMem[2]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ads [4];
    logic [31:0] exp [4];
    logic [31:0] got [4];
    int when [4];
    logic ee; int el, ew, idx, nResp;
    bit pend;
    for (int i = 0; i < 4; i++) begin
      ads[i] = 32'($urandom_range(0, 63)) * 4;
      model_txn(3'd0, ads[i], 32'h0, exp[i], ee, el, ew);
      got[i] = '0; when[i] = 0;
    end
    idx = 0; nResp = 0;
    @(negedge Clk);
    Req = 1'b1; ReqOp = 3'd0; ReqAddr = ads[0];
    pend = Ready;
    for (int c = 1; c < 14; c++) begin
      @(negedge Clk);
      if (RespValid && nResp < 4) begin got[nResp] = RespData; when[nResp] = c; nResp++; end
      if (pend) begin
        idx++;
        if (idx < 4) ReqAddr = ads[idx]; else Req = 1'b0;
      end
      pend = Req && Ready;
    end
    total++; if (nResp !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nResp); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, got[i], exp[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      total++; if (when[i] - when[i-1] !== 2) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=2", i, when[i] - when[i-1]); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] addr, data, rd, wa, er; logic err, ee;
    int lat, wrs, rl, el, ew;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h400 * 32'($urandom_range(1, 1000));
      data = $urandom;
      model_txn(op, addr, data, er, ee, el, ew);
      do_txn(op, addr, data, rd, err, lat, wrs, wa, rl);
      total++;
      if (rd !== er || err !== ee || lat !== el || wrs !== ew) begin
        bad++;
        $display("FAIL rand[%0d] op=%0d addr=%h got data=%h err=%b lat=%0d wrs=%0d want data=%h err=%b lat=%0d wrs=%0d",
                 n, op, addr, rd, err, lat, wrs, er, ee, el, ew);
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (mem[i] !== refMem[i]) begin bad++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, mem[i], refMem[i]); end
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_sw_lw();
    test_load_ext();
    test_sb_rmw();
    test_faults();
    test_reset_in_rmw();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
